uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter: the successor to the fixed 8-bit, free-running serialiser. Accepts bytes over a valid/ready handshake, frames each with start bit, 5–9 data bits, optional parity and 1 or 2 stop bits, and drives a registered serial line. Bit timing comes from a clock-enable tick, not a derived clock, so all logic stays on the single system clock. Sits between the board top level and the TX pin.

## Interface
- DATA_BITS, 8, data bits per frame, legal range 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits per frame, 1 or 2
- MSB_FIRST, 0, 0 = LSB first (UART standard), 1 = MSB first
- DIV_W, 24, divisor width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- divisor  in  DIV_W  bit period = divisor+1 clk cycles
- tx_data  in  DATA_BITS  word to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  block can accept a word this cycle
- tx  out  1  serial line, idle high, registered
- busy  out  1  frame in progress

## Operation
- States: IDLE, START, DATA, PARITY, STOP. PARITY skipped when PARITY=0.
- Transfer occurs on a rising edge with tx_valid && tx_ready; tx_data and divisor latched at that edge; later changes to either input do not affect the frame in flight.
- tx_ready = (state==IDLE) or (state==STOP, last stop bit, bit counter == latched divisor). Combinational from registered state only; no path from tx_valid.
- On transfer: state -> START, bit-period counter cleared, so the start bit is exactly divisor+1 cycles.
- Each bit held divisor+1 cycles; at the tick ending a bit, advance: START -> DATA (bit index 0), DATA index DATA_BITS-1 -> PARITY or STOP, PARITY -> STOP, STOP last -> IDLE, or -> START if a new transfer occurs on that same edge (back-to-back, zero idle cycles).
- Data order: index i sends tx_data[i] (MSB_FIRST=0) or tx_data[DATA_BITS-1-i].
- Parity: even -> XOR of data bits; odd -> its inverse (total ones including parity bit is odd).
- busy = (state != IDLE).
- tx_valid while not ready: ignored, no transfer; the source holds data.

## Timing
- Reset (async assert): state IDLE, tx=1, tx_ready=1, busy=0, counters 0. Reset mid-frame aborts immediately; line returns high without completing the frame.
- Transfer at edge E: tx=0 from E+1; frame length F = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*(divisor+1) cycles; tx_ready re-asserts during cycle E+F (last stop cycle).
- divisor=0: one bit per clk cycle, legal.
- Counter compare is equality against latched divisor, DIV_W bits, no wrap-around hazard.

## Structure
- Package uart_pkg: parity-mode constants PARITY_NONE/ODD/EVEN, state encoding localparams.
- Sub-module uart_baud_tick: DIV_W counter with synchronous clear and divisor input; outputs one-cycle tick when count == divisor, then reloads 0. Clock-enable only, never used as a clock.
- Top: FSM, shift/index register, parity accumulator, registered tx.

## Test plan
- 8N1, divisor=3, tx_data=0xA5: tx = 0,1,0,1,0,0,1,0,1,1, each 4 cycles; frame 40 cycles; tx_ready low 39 cycles, high in cycle 40.
- 8E1 0x03 -> parity bit 0; 8O1 0x03 -> parity bit 1; 7O2, MSB_FIRST=1, 0x01 -> data 0000001, parity 0, two stop bits.
- Back-to-back: tx_valid held high with 0x55 then 0xAA, divisor=1: second start bit immediately follows first stop bit, no idle cycle.
- Divisor changed 3->7 mid-frame: current frame keeps 4-cycle bits; next frame uses 8-cycle bits.
- rst_n low mid-DATA: tx=1, busy=0, tx_ready=1 same cycle (async); after release, new frame sends cleanly.
- divisor=0, 8N1, 0xFF: frame lasts 10 cycles, tx = 0 then nine 1s.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmitter: parity modes, FSM state encoding
// and the parity helper used when a word is latched.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_ODD  = 2'd1;
  localparam logic [1:0] PARITY_EVEN = 2'd2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } tx_state_e;

  // Data is zero-extended to 9 bits, so padding never changes the XOR.
  function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
    logic even_s;
    even_s = ^data;
    case (mode)
      PARITY_ODD:  parity_bit = ~even_s;
      PARITY_EVEN: parity_bit = even_s;
      default:     parity_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Word handshake between a byte source and the UART transmitter.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: emits a one-cycle clock-enable when the count reaches
// the divisor, then restarts from zero.
module uart_baud_tick #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_r;

  assign tick = (cnt_r == divisor);

  // Period counter, cleared on demand and reloaded after each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr || tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: frames handshaked words with start, data, optional parity
// and stop bits onto a registered serial line timed by a clock-enable tick.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int MSB_FIRST = 0,
  parameter int DIV_W     = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] divisor,
  uart_tx_frame_if.slave   bus,
  output logic             tx,
  output logic             busy
);

  localparam logic [1:0] PAR_MODE   = 2'(PARITY);
  localparam logic       HAS_PARITY = (PAR_MODE != PARITY_NONE);
  localparam logic       MSB        = (MSB_FIRST != 0);
  localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);

  tx_state_e            state_r;
  tx_state_e            state_nxt_s;
  logic [3:0]           idx_r;
  logic [3:0]           idx_nxt_s;
  logic [DATA_BITS-1:0] data_r;
  logic [DIV_W-1:0]     div_r;
  logic                 parity_r;
  logic                 tx_r;
  logic                 tx_nxt_s;
  logic                 tick_s;
  logic                 ready_s;
  logic                 accept_s;
  logic                 cnt_clr_s;
  logic                 last_stop_s;
  logic [15:0]          data_ext_s;
  logic [3:0]           bit_sel_s;

  // Ready depends only on registered state so there is no path from tx_valid.
  assign last_stop_s = (idx_r == LAST_STOP);
  assign ready_s     = (state_r == S_IDLE) ||
                       ((state_r == S_STOP) && last_stop_s && tick_s);
  assign accept_s    = bus.tx_valid && ready_s;
  assign cnt_clr_s   = (state_r == S_IDLE) || accept_s;

  assign bus.tx_ready = ready_s;
  assign busy         = (state_r != S_IDLE);
  assign tx           = tx_r;

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr_s),
    .divisor (div_r),
    .tick    (tick_s)
  );

  // Next-state and bit-index logic, advancing only at the end of a bit period.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nxt_s = S_START;
          idx_nxt_s   = 4'd0;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_START: begin
        if (tick_s) begin
          state_nxt_s = S_DATA;
          idx_nxt_s   = 4'd0;
        end else begin
          state_nxt_s = S_START;
        end
      end
      S_DATA: begin
        if (tick_s && (idx_r == LAST_DATA)) begin
          idx_nxt_s = 4'd0;
          if (HAS_PARITY) begin
            state_nxt_s = S_PARITY;
          end else begin
            state_nxt_s = S_STOP;
          end
        end else if (tick_s) begin
          idx_nxt_s = idx_r + 4'd1;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_PARITY: begin
        if (tick_s) begin
          state_nxt_s = S_STOP;
          idx_nxt_s   = 4'd0;
        end else begin
          state_nxt_s = S_PARITY;
        end
      end
      S_STOP: begin
        if (tick_s && last_stop_s && accept_s) begin
          state_nxt_s = S_START;
          idx_nxt_s   = 4'd0;
        end else if (tick_s && last_stop_s) begin
          state_nxt_s = S_IDLE;
          idx_nxt_s   = 4'd0;
        end else if (tick_s) begin
          idx_nxt_s = idx_r + 4'd1;
        end else begin
          state_nxt_s = S_STOP;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        idx_nxt_s   = 4'd0;
      end
    endcase
  end

  // Line level for the upcoming cycle, so tx itself can be a plain flop.
  always_comb begin
    data_ext_s = 16'(data_r);
    if (MSB) begin
      bit_sel_s = LAST_DATA - idx_nxt_s;
    end else begin
      bit_sel_s = idx_nxt_s;
    end
    case (state_nxt_s)
      S_IDLE:   tx_nxt_s = 1'b1;
      S_START:  tx_nxt_s = 1'b0;
      S_DATA:   tx_nxt_s = data_ext_s[bit_sel_s];
      S_PARITY: tx_nxt_s = parity_r;
      S_STOP:   tx_nxt_s = 1'b1;
      default:  tx_nxt_s = 1'b1;
    endcase
  end

  // FSM state, bit index and serial line register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      idx_r   <= 4'd0;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      tx_r    <= tx_nxt_s;
    end
  end

  // Word, divisor and parity are captured at the transfer edge and held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r   <= '0;
      div_r    <= '0;
      parity_r <= 1'b0;
    end else if (accept_s) begin
      data_r   <= bus.tx_data;
      div_r    <= divisor;
      parity_r <= parity_bit(9'(bus.tx_data), PAR_MODE);
    end else begin
      data_r   <= data_r;
      div_r    <= div_r;
      parity_r <= parity_r;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame across 8N1, 8E1, 8O1 and 7O2/MSB-first builds.
module tb_uart_tx_frame;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] divisor;
  logic        tx0, tx1, tx2, tx3;
  logic        busy0, busy1, busy2, busy3;
  int          total = 0;
  int          bad = 0;
  logic        cap_tx[$];
  logic        cap_rdy[$];
  logic        cap_busy[$];

  always #5 clk = ~clk;

  uart_tx_frame_if #(.DATA_BITS(8)) if0 ();
  uart_tx_frame_if #(.DATA_BITS(8)) if1 ();
  uart_tx_frame_if #(.DATA_BITS(8)) if2 ();
  uart_tx_frame_if #(.DATA_BITS(7)) if3 ();

  uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .MSB_FIRST(0), .DIV_W(24))
    dut0 (.clk(clk), .rst_n(rst_n), .divisor(divisor), .bus(if0), .tx(tx0), .busy(busy0));
  uart_tx_frame #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .MSB_FIRST(0), .DIV_W(24))
    dut1 (.clk(clk), .rst_n(rst_n), .divisor(divisor), .bus(if1), .tx(tx1), .busy(busy1));
  uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .MSB_FIRST(0), .DIV_W(24))
    dut2 (.clk(clk), .rst_n(rst_n), .divisor(divisor), .bus(if2), .tx(tx2), .busy(busy2));
  uart_tx_frame #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .MSB_FIRST(1), .DIV_W(24))
    dut3 (.clk(clk), .rst_n(rst_n), .divisor(divisor), .bus(if3), .tx(tx3), .busy(busy3));

  task automatic set_data(input int sel, input logic [8:0] d);
    case (sel)
      0: if0.tx_data = d[7:0];
      1: if1.tx_data = d[7:0];
      2: if2.tx_data = d[7:0];
      3: if3.tx_data = d[6:0];
      default: ;
    endcase
  endtask

  task automatic set_valid(input int sel, input logic v);
    case (sel)
      0: if0.tx_valid = v;
      1: if1.tx_valid = v;
      2: if2.tx_valid = v;
      3: if3.tx_valid = v;
      default: ;
    endcase
  endtask

  function automatic logic [2:0] get_out(input int sel);
    case (sel)
      0: get_out = {tx0, if0.tx_ready, busy0};
      1: get_out = {tx1, if1.tx_ready, busy1};
      2: get_out = {tx2, if2.tx_ready, busy2};
      3: get_out = {tx3, if3.tx_ready, busy3};
      default: get_out = 3'b000;
    endcase
  endfunction

  // Present a word just before an edge; the transfer happens on that edge.
  task automatic start_frame(input int sel, input logic [8:0] d, input logic [23:0] div,
                             input logic hold);
    @(negedge clk);
    divisor = div;
    set_data(sel, d);
    set_valid(sel, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) set_valid(sel, 1'b0);
  endtask

  // Record n cycles after the transfer edge; optionally drop valid after cycle drop_at.
  task automatic capture(input int sel, input int n, input int drop_at);
    logic [2:0] o;
    cap_tx.delete();
    cap_rdy.delete();
    cap_busy.delete();
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      o = get_out(sel);
      cap_tx.push_back(o[2]);
      cap_rdy.push_back(o[1]);
      cap_busy.push_back(o[0]);
      if (k == drop_at) set_valid(sel, 1'b0);
    end
  endtask

  task automatic test_reset();
    logic [2:0] o;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      o = get_out(s);
      total++; if (o[2] !== 1'b1) begin bad++; $display("FAIL reset_tx dut%0d got=%b exp=1", s, o[2]); end
      total++; if (o[1] !== 1'b1) begin bad++; $display("FAIL reset_ready dut%0d got=%b exp=1", s, o[1]); end
      total++; if (o[0] !== 1'b0) begin bad++; $display("FAIL reset_busy dut%0d got=%b exp=0", s, o[0]); end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_8n1();
    logic [15:0] fr, t;
    logic        e_tx, e_rdy, e_busy;
    fr = 16'b0101001011;
    start_frame(0, 9'h0A5, 24'd3, 1'b0);
    capture(0, 44, 0);
    for (int k = 1; k <= 44; k++) begin
      if (k <= 40) begin t = fr >> (9 - (k - 1) / 4); e_tx = t[0]; end
      else e_tx = 1'b1;
      e_rdy  = (k >= 40);
      e_busy = (k <= 40);
      total++; if (cap_tx[k-1] !== e_tx) begin bad++; $display("FAIL 8n1_tx k=%0d got=%b exp=%b", k, cap_tx[k-1], e_tx); end
      total++; if (cap_rdy[k-1] !== e_rdy) begin bad++; $display("FAIL 8n1_ready k=%0d got=%b exp=%b", k, cap_rdy[k-1], e_rdy); end
      total++; if (cap_busy[k-1] !== e_busy) begin bad++; $display("FAIL 8n1_busy k=%0d got=%b exp=%b", k, cap_busy[k-1], e_busy); end
    end
  endtask

  task automatic test_parity();
    logic [15:0] fr, t;
    logic [8:0]  d;
    logic        e_tx, e_rdy, e_busy;
    int          sel;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin sel = 1; d = 9'h003; fr = 16'b01100000001; end
        1: begin sel = 2; d = 9'h003; fr = 16'b01100000011; end
        default: begin sel = 3; d = 9'h001; fr = 16'b00000001011; end
      endcase
      start_frame(sel, d, 24'd1, 1'b0);
      capture(sel, 24, 0);
      for (int k = 1; k <= 24; k++) begin
        if (k <= 22) begin t = fr >> (10 - (k - 1) / 2); e_tx = t[0]; end
        else e_tx = 1'b1;
        e_rdy  = (k >= 22);
        e_busy = (k <= 22);
        total++; if (cap_tx[k-1] !== e_tx) begin bad++; $display("FAIL parity_tx dut%0d k=%0d got=%b exp=%b", sel, k, cap_tx[k-1], e_tx); end
        total++; if (cap_rdy[k-1] !== e_rdy) begin bad++; $display("FAIL parity_ready dut%0d k=%0d got=%b exp=%b", sel, k, cap_rdy[k-1], e_rdy); end
        total++; if (cap_busy[k-1] !== e_busy) begin bad++; $display("FAIL parity_busy dut%0d k=%0d got=%b exp=%b", sel, k, cap_busy[k-1], e_busy); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] fa, fb, t;
    logic        e_tx, e_rdy, e_busy;
    fa = 16'b0101010101;
    fb = 16'b0010101011;
    start_frame(0, 9'h055, 24'd1, 1'b1);
    set_data(0, 9'h0AA);
    capture(0, 42, 21);
    for (int k = 1; k <= 42; k++) begin
      if (k <= 20) begin t = fa >> (9 - (k - 1) / 2); e_tx = t[0]; end
      else if (k <= 40) begin t = fb >> (9 - (k - 21) / 2); e_tx = t[0]; end
      else e_tx = 1'b1;
      e_rdy  = (k == 20) || (k >= 40);
      e_busy = (k <= 40);
      total++; if (cap_tx[k-1] !== e_tx) begin bad++; $display("FAIL b2b_tx k=%0d got=%b exp=%b", k, cap_tx[k-1], e_tx); end
      total++; if (cap_rdy[k-1] !== e_rdy) begin bad++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, cap_rdy[k-1], e_rdy); end
      total++; if (cap_busy[k-1] !== e_busy) begin bad++; $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, cap_busy[k-1], e_busy); end
    end
  endtask

  // Divisor and data change after the transfer; valid is held but ignored while busy.
  task automatic test_div_change();
    logic [15:0] fa, fb, t;
    logic        e_tx, e_rdy, e_busy;
    fa = 16'b0111100001;
    fb = 16'b0000011111;
    start_frame(0, 9'h00F, 24'd3, 1'b1);
    divisor = 24'd7;
    set_data(0, 9'h0F0);
    capture(0, 124, 41);
    for (int k = 1; k <= 124; k++) begin
      if (k <= 40) begin t = fa >> (9 - (k - 1) / 4); e_tx = t[0]; end
      else if (k <= 120) begin t = fb >> (9 - (k - 41) / 8); e_tx = t[0]; end
      else e_tx = 1'b1;
      e_rdy  = (k == 40) || (k >= 120);
      e_busy = (k <= 120);
      total++; if (cap_tx[k-1] !== e_tx) begin bad++; $display("FAIL divchg_tx k=%0d got=%b exp=%b", k, cap_tx[k-1], e_tx); end
      total++; if (cap_rdy[k-1] !== e_rdy) begin bad++; $display("FAIL divchg_ready k=%0d got=%b exp=%b", k, cap_rdy[k-1], e_rdy); end
      total++; if (cap_busy[k-1] !== e_busy) begin bad++; $display("FAIL divchg_busy k=%0d got=%b exp=%b", k, cap_busy[k-1], e_busy); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] fr, t;
    logic [2:0]  o;
    logic        e_tx, e_rdy, e_busy;
    divisor = 24'd3;
    start_frame(0, 9'h0A5, 24'd3, 1'b0);
    capture(0, 18, 0);
    total++; if (cap_tx[17] !== 1'b0) begin bad++; $display("FAIL rstmid_pre_tx got=%b exp=0", cap_tx[17]); end
    total++; if (cap_busy[17] !== 1'b1) begin bad++; $display("FAIL rstmid_pre_busy got=%b exp=1", cap_busy[17]); end
    rst_n = 1'b0;
    #1;
    o = get_out(0);
    total++; if (o[2] !== 1'b1) begin bad++; $display("FAIL rstmid_tx got=%b exp=1", o[2]); end
    total++; if (o[1] !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", o[1]); end
    total++; if (o[0] !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", o[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    fr = 16'b0001111001;
    start_frame(0, 9'h03C, 24'd1, 1'b0);
    capture(0, 22, 0);
    for (int k = 1; k <= 22; k++) begin
      if (k <= 20) begin t = fr >> (9 - (k - 1) / 2); e_tx = t[0]; end
      else e_tx = 1'b1;
      e_rdy  = (k >= 20);
      e_busy = (k <= 20);
      total++; if (cap_tx[k-1] !== e_tx) begin bad++; $display("FAIL rstmid_frame_tx k=%0d got=%b exp=%b", k, cap_tx[k-1], e_tx); end
      total++; if (cap_rdy[k-1] !== e_rdy) begin bad++; $display("FAIL rstmid_frame_ready k=%0d got=%b exp=%b", k, cap_rdy[k-1], e_rdy); end
      total++; if (cap_busy[k-1] !== e_busy) begin bad++; $display("FAIL rstmid_frame_busy k=%0d got=%b exp=%b", k, cap_busy[k-1], e_busy); end
    end
  endtask

  task automatic test_div0();
    logic e_tx, e_rdy, e_busy;
    start_frame(0, 9'h0FF, 24'd0, 1'b0);
    capture(0, 12, 0);
    for (int k = 1; k <= 12; k++) begin
      e_tx   = (k != 1);
      e_rdy  = (k >= 10);
      e_busy = (k <= 10);
      total++; if (cap_tx[k-1] !== e_tx) begin bad++; $display("FAIL div0_tx k=%0d got=%b exp=%b", k, cap_tx[k-1], e_tx); end
      total++; if (cap_rdy[k-1] !== e_rdy) begin bad++; $display("FAIL div0_ready k=%0d got=%b exp=%b", k, cap_rdy[k-1], e_rdy); end
      total++; if (cap_busy[k-1] !== e_busy) begin bad++; $display("FAIL div0_busy k=%0d got=%b exp=%b", k, cap_busy[k-1], e_busy); end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    divisor      = 24'd3;
    if0.tx_data  = 8'h00;
    if1.tx_data  = 8'h00;
    if2.tx_data  = 8'h00;
    if3.tx_data  = 7'h00;
    if0.tx_valid = 1'b0;
    if1.tx_valid = 1'b0;
    if2.tx_valid = 1'b0;
    if3.tx_valid = 1'b0;
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_div_change();
    test_reset_mid();
    test_div0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
